alu_control: RTL and testbench

- Registered ALU-control decoder for the RV32I integer datapath.
- Maps the main decoder's 2-bit alu_op, plus instruction fields func3/func7, to a 4-bit ALU operation code.
- Sits between the main control unit and the ALU.
- Also flags illegal R-type, I-type and branch encodings.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_control_if.sv | 36 +++
 rtl/alu_control_decode.sv | 92 +++++++++
 rtl/alu_control.sv | 40 ++++
 tb/tb_alu_control.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I ALU-control slice.
// Contents:
//   alu_code_e  - 4-bit ALU operation codes consumed by the ALU
//   ALUOP_*     - operation class from the main decoder
//   F7_*        - func7 values that select base/alternate R-type and shift ops
//   decode_t    - combinational decode result {result, illegal}
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_code_e;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_code_e result;
        logic      illegal;
    } decode_t;

endpackage

// File: rtl/alu_control_if.sv
// Bus between the main control unit / instruction fields and the ALU.
// Signals:
//   func3   - instruction bits [14:12]
//   func7   - instruction bits [31:25]
//   alu_op  - operation class from the main decoder
//   result  - registered ALU operation code
//   illegal - registered "encoding not supported" flag
// Modports:
//   master - drives the instruction fields, observes the decode
//   slave  - the ALU-control block
interface alu_control_if;
    import alu_pkg::*;

    logic [2:0] func3;
    logic [6:0] func7;
    logic [1:0] alu_op;
    logic [3:0] result;
    logic       illegal;

    modport master (
        output func3,
        output func7,
        output alu_op,
        input  result,
        input  illegal
    );

    modport slave (
        input  func3,
        input  func7,
        input  alu_op,
        output result,
        output illegal
    );

endinterface

// File: rtl/alu_control_decode.sv
// Purely combinational ALU-control decode.
// Ports:
//   func3  (in, 3) - instruction bits [14:12]
//   func7  (in, 7) - instruction bits [31:25]
//   alu_op (in, 2) - operation class
//   dec    (out)   - {result, illegal}; illegal encodings decode to ADD
module alu_control_decode
    import alu_pkg::*;
(
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic [1:0] alu_op,
    output decode_t    dec
);

    always_comb begin
        // NOTE: defaults first so every path assigns both fields and no latch is inferred;
        // they also encode the "illegal -> ADD" fallback.
        dec.result  = ALU_ADD;
        dec.illegal = 1'b0;

        unique case (alu_op)
            ALUOP_MEM: begin
                dec.result = ALU_ADD;
            end

            ALUOP_BR: begin
                // func3[2:1] selects the comparison kind; func3[0] only inverts
                // the branch sense, which the branch unit handles.
                unique case (func3[2:1])
                    2'b00: dec.result = ALU_SUB;
                    2'b01: begin
                        dec.result  = ALU_SUB;
                        dec.illegal = 1'b1;
                    end
                    2'b10: dec.result = ALU_SLT;
                    2'b11: dec.result = ALU_SLTU;
                    default: ;
                endcase
            end

            ALUOP_R: begin
                if (func7 == F7_BASE) begin
                    unique case (func3)
                        3'b000: dec.result = ALU_ADD;
                        3'b001: dec.result = ALU_SLL;
                        3'b010: dec.result = ALU_SLT;
                        3'b011: dec.result = ALU_SLTU;
                        3'b100: dec.result = ALU_XOR;
                        3'b101: dec.result = ALU_SRL;
                        3'b110: dec.result = ALU_OR;
                        3'b111: dec.result = ALU_AND;
                        default: ;
                    endcase
                end else if (func7 == F7_ALT && func3 == 3'b000) begin
                    dec.result = ALU_SUB;
                end else if (func7 == F7_ALT && func3 == 3'b101) begin
                    dec.result = ALU_SRA;
                end else begin
                    // Includes the M extension (func7=0000001), not supported here.
                    dec.illegal = 1'b1;
                end
            end

            ALUOP_I: begin
                // func7 is part of the immediate except for shifts, where it
                // carries the shift type.
                unique case (func3)
                    3'b000: dec.result = ALU_ADD;
                    3'b010: dec.result = ALU_SLT;
                    3'b011: dec.result = ALU_SLTU;
                    3'b100: dec.result = ALU_XOR;
                    3'b110: dec.result = ALU_OR;
                    3'b111: dec.result = ALU_AND;
                    3'b001: begin
                        if (func7 == F7_BASE) dec.result  = ALU_SLL;
                        else                  dec.illegal = 1'b1;
                    end
                    3'b101: begin
                        if (func7 == F7_BASE)     dec.result  = ALU_SRL;
                        else if (func7 == F7_ALT) dec.result  = ALU_SRA;
                        else                      dec.illegal = 1'b1;
                    end
                    default: ;
                endcase
            end

            default: ;
        endcase
    end

endmodule

// File: rtl/alu_control.sv
// Registered ALU-control decoder for the RV32I datapath.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset; forces result=ADD, illegal=0
//   bus - alu_control_if.slave: func3/func7/alu_op in, result/illegal out
// Outputs follow the inputs sampled at the previous rising edge (1-cycle latency).
module alu_control
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    alu_control_if.slave  bus
);

    decode_t dec_d;
    decode_t dec_q;

    alu_control_decode u_decode (
        .func3  (bus.func3),
        .func7  (bus.func7),
        .alu_op (bus.alu_op),
        .dec    (dec_d)
    );

    // NOTE: reset value is ADD (not all-zeros = AND) so a datapath coming out of
    // reset computes a harmless address add.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all sequential state.
            dec_q.result  <= ALU_ADD;
            dec_q.illegal <= 1'b0;
        end else begin
            dec_q <= dec_d;
        end
    end

    assign bus.result  = dec_q.result;
    assign bus.illegal = dec_q.illegal;

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: reset, directed vector table,
// pipelined random legal encodings against a reference model, async reset mid-stream.
module tb_alu_control;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    alu_control_if bus ();

    alu_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] exp_res;
        logic       exp_ill;
    } vec_t;

    vec_t vecs[18];

    // Reference tables, written from the opcode map.
    logic [3:0] r_base_tbl[8] = '{4'b0010, 4'b0100, 4'b1000, 4'b1001,
                                  4'b0011, 4'b0101, 4'b0001, 4'b0000};
    logic [3:0] br_tbl[8]     = '{4'b0110, 4'b0110, 4'b0110, 4'b0110,
                                  4'b1000, 4'b1000, 4'b1001, 4'b1001};

    function automatic logic [4:0] ref_decode(input logic [1:0] op,
                                              input logic [2:0] f3,
                                              input logic [6:0] f7);
        logic [4:0] r;
        r = {1'b0, 4'b0010};
        case (op)
            2'b00: r = {1'b0, 4'b0010};
            2'b01: r = {(f3 == 3'd2 || f3 == 3'd3), br_tbl[f3]};
            2'b10: begin
                if (f7 == 7'h00)                     r = {1'b0, r_base_tbl[f3]};
                else if (f7 == 7'h20 && f3 == 3'd0)  r = {1'b0, 4'b0110};
                else if (f7 == 7'h20 && f3 == 3'd5)  r = {1'b0, 4'b0111};
                else                                 r = {1'b1, 4'b0010};
            end
            default: begin
                if (f3 == 3'd1)
                    r = (f7 == 7'h00) ? {1'b0, 4'b0100} : {1'b1, 4'b0010};
                else if (f3 == 3'd5)
                    r = (f7 == 7'h00) ? {1'b0, 4'b0101} :
                        (f7 == 7'h20) ? {1'b0, 4'b0111} : {1'b1, 4'b0010};
                else
                    r = {1'b0, r_base_tbl[f3]};
            end
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
        bus.alu_op = op;
        bus.func3  = f3;
        bus.func7  = f7;
    endtask

    // Random encoding that the decoder accepts as legal.
    task automatic pick_legal(output logic [1:0] op, output logic [2:0] f3, output logic [6:0] f7);
        op = 2'($urandom_range(0, 3));
        f3 = 3'($urandom_range(0, 7));
        f7 = 7'($urandom);
        case (op)
            2'b01: if (f3 == 3'd2 || f3 == 3'd3) f3 = f3 + 3'd2;
            2'b10: begin
                if ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) f7 = 7'h20;
                else f7 = 7'h00;
            end
            2'b11: begin
                if (f3 == 3'd1) f7 = 7'h00;
                else if (f3 == 3'd5) f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
            default: ;
        endcase
    endtask

    initial begin
        logic [1:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] exp;

        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{"r_sub",      2'b10, 3'b000, 7'h20, 4'b0110, 1'b0};
        vecs[1]  = '{"r_add",      2'b10, 3'b000, 7'h00, 4'b0010, 1'b0};
        vecs[2]  = '{"r_or",       2'b10, 3'b110, 7'h00, 4'b0001, 1'b0};
        vecs[3]  = '{"r_sra",      2'b10, 3'b101, 7'h20, 4'b0111, 1'b0};
        vecs[4]  = '{"r_and",      2'b10, 3'b111, 7'h00, 4'b0000, 1'b0};
        vecs[5]  = '{"r_alt_bad",  2'b10, 3'b001, 7'h20, 4'b0010, 1'b1};
        vecs[6]  = '{"r_mext",     2'b10, 3'b000, 7'h01, 4'b0010, 1'b1};
        vecs[7]  = '{"i_addi_f7",  2'b11, 3'b000, 7'h20, 4'b0010, 1'b0};
        vecs[8]  = '{"i_srai",     2'b11, 3'b101, 7'h20, 4'b0111, 1'b0};
        vecs[9]  = '{"i_slli_bad", 2'b11, 3'b001, 7'h20, 4'b0010, 1'b1};
        vecs[10] = '{"br_beq",     2'b01, 3'b000, 7'h55, 4'b0110, 1'b0};
        vecs[11] = '{"br_blt",     2'b01, 3'b100, 7'h00, 4'b1000, 1'b0};
        vecs[12] = '{"br_bgeu",    2'b01, 3'b111, 7'h7f, 4'b1001, 1'b0};
        vecs[13] = '{"br_bad",     2'b01, 3'b010, 7'h00, 4'b0110, 1'b1};
        vecs[14] = '{"mem",        2'b00, 3'b111, 7'h7f, 4'b0010, 1'b0};
        vecs[15] = '{"i_sltiu",    2'b11, 3'b011, 7'h55, 4'b1001, 1'b0};
        vecs[16] = '{"r_slt",      2'b10, 3'b010, 7'h00, 4'b1000, 1'b0};
        vecs[17] = '{"i_srli",     2'b11, 3'b101, 7'h00, 4'b0101, 1'b0};

        // Reset with an illegal encoding on the inputs.
        rst = 1'b1;
        drive(2'b10, 3'b001, 7'h20);
        #2;
        check("rst_result", 32'(bus.result), 32'h2);
        check("rst_illegal", 32'(bus.illegal), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_hold_result", 32'(bus.result), 32'h2);

        // Release reset with R-type OR; output must not change until the next edge.
        @(negedge clk);
        rst = 1'b0;
        drive(2'b10, 3'b110, 7'h00);
        #1;
        check("post_rst_not_early", 32'(bus.result), 32'h2);
        @(posedge clk);
        #1;
        check("post_rst_or", 32'(bus.result), 32'h1);
        check("post_rst_or_ill", 32'(bus.illegal), 32'h0);

        // Directed vector table.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].f3, vecs[i].f7);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_result"}, 32'(bus.result), 32'(vecs[i].exp_res));
            check({vecs[i].name, "_illegal"}, 32'(bus.illegal), 32'(vecs[i].exp_ill));
        end

        // Back-to-back legal encodings: each output reflects the prior edge's inputs.
        exp = {vecs[17].exp_ill, vecs[17].exp_res};
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("pipe_hold", 32'({bus.illegal, bus.result}), 32'(exp));
            pick_legal(op, f3, f7);
            drive(op, f3, f7);
            exp = ref_decode(op, f3, f7);
            @(posedge clk);
            #1;
            check("pipe_result", 32'(bus.result), 32'(exp[3:0]));
            check("pipe_illegal", 32'(bus.illegal), 32'(exp[4]));
        end

        // Async reset mid-stream: load AND, then assert rst between edges.
        @(negedge clk);
        drive(2'b10, 3'b111, 7'h00);
        @(posedge clk);
        #1;
        check("pre_rst_and", 32'(bus.result), 32'h0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_result", 32'(bus.result), 32'h2);
        check("mid_rst_illegal", 32'(bus.illegal), 32'h0);
        @(posedge clk);
        #1;
        check("mid_rst_held", 32'(bus.result), 32'h2);
        @(negedge clk);
        rst = 1'b0;
        drive(2'b01, 3'b110, 7'h00);
        @(posedge clk);
        #1;
        check("after_mid_rst", 32'(bus.result), 32'h9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
